fetch_unit: RTL

Parametrised instruction-fetch stage for the riscie pipeline. It is the successor of the single-register fetch stage. It drives a valid/ready instruction-memory request port with in-order responses, buffers returned words in a FETCH_DEPTH-entry fetch queue, and presents one instruction per cycle to the IF/ID register under a valid/ready stall handshake. A branch redirect (pcSrc) flushes the queue and squashes any responses still in flight.

---
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory request/response channel and the IF/ID
// handshake of the fetch stage. The master modport is the fetch unit's view.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imemReqValid;
    logic            imemReqReady;
    logic [XLEN-1:0] imemReqAddr;
    logic            imemRspValid;
    logic [XLEN-1:0] imemRspData;
    logic            ifidValid;
    logic            ifidReady;
    logic [XLEN-1:0] ifidINST;
    logic [XLEN-1:0] ifidPc;

    modport master (
        output imemReqValid,
        output imemReqAddr,
        input  imemReqReady,
        input  imemRspValid,
        input  imemRspData,
        output ifidValid,
        output ifidINST,
        output ifidPc,
        input  ifidReady
    );

    modport slave (
        input  imemReqValid,
        input  imemReqAddr,
        output imemReqReady,
        output imemRspValid,
        output imemRspData,
        input  ifidValid,
        input  ifidINST,
        input  ifidPc,
        output ifidReady
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited request issue, in-order response
// queue, IF/ID output register with stall handshake, and branch redirect.
module fetch_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              FETCH_DEPTH = 4,
    parameter logic [XLEN-1:0] NOP_INST    = 'h13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pcSrc,
    input  logic [XLEN-1:0] branchAddr,
    fetch_unit_if.master    bus
);
    localparam int AW = $clog2(FETCH_DEPTH);
    localparam int CW = AW + 1;

    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0] fetchPcReg, fetchPcNext;
    logic [XLEN-1:0] rspPcReg, rspPcNext;
    cnt_t            countReg, countNext;
    cnt_t            outstReg, outstNext;
    cnt_t            dropReg, dropNext;
    logic [AW-1:0]   wrPtrReg, wrPtrNext;
    logic [AW-1:0]   rdPtrReg, rdPtrNext;
    logic            issueEnReg;
    logic            ifidValidReg, ifidValidNext;
    logic [XLEN-1:0] ifidInstReg, ifidInstNext;
    logic [XLEN-1:0] ifidPcReg, ifidPcNext;

    logic [XLEN-1:0] qPc   [FETCH_DEPTH];
    logic [XLEN-1:0] qInst [FETCH_DEPTH];

    logic [XLEN-1:0] target;
    logic [CW:0]     inUse;
    logic            reqValid, reqFire;
    logic            rspAccept, rspKeep;
    logic            loadOut, queueNonEmpty, pop;
    logic [1:0]      unusedAddrBits;

    assign target         = {branchAddr[XLEN-1:2], 2'b00};
    assign unusedAddrBits = branchAddr[1:0];

    // Queue entries plus in-flight requests may never exceed the queue size,
    // so every response that is kept is guaranteed a free slot.
    assign inUse    = {1'b0, countReg} + {1'b0, outstReg};
    assign reqValid = issueEnReg && !pcSrc && (inUse < (CW+1)'(FETCH_DEPTH));
    assign reqFire  = reqValid && bus.imemReqReady;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rspAccept     = bus.imemRspValid && (outstReg != '0);
    assign rspKeep       = rspAccept && (dropReg == '0) && !pcSrc;
    assign loadOut       = !ifidValidReg || bus.ifidReady;
    assign queueNonEmpty = (countReg != '0);
    assign pop           = loadOut && queueNonEmpty && !pcSrc;

    always_comb begin
        fetchPcNext   = fetchPcReg;
        rspPcNext     = rspPcReg;
        countNext     = countReg;
        dropNext      = dropReg;
        wrPtrNext     = wrPtrReg;
        rdPtrNext     = rdPtrReg;
        ifidValidNext = ifidValidReg;
        ifidInstNext  = ifidInstReg;
        ifidPcNext    = ifidPcReg;
        outstNext     = outstReg + cnt_t'(reqFire) - cnt_t'(rspAccept);

        if (pcSrc) begin
            // Everything still in flight after this cycle belongs to the
            // abandoned path; a response arriving now is discarded as well.
            fetchPcNext   = target;
            rspPcNext     = target;
            countNext     = '0;
            wrPtrNext     = '0;
            rdPtrNext     = '0;
            dropNext      = outstNext;
            ifidValidNext = 1'b0;
            ifidInstNext  = NOP_INST;
        end else begin
            if (reqFire) begin
                fetchPcNext = fetchPcReg + XLEN'(4);
            end
            if (rspAccept) begin
                if (dropReg != '0) begin
                    dropNext = dropReg - cnt_t'(1);
                end else begin
                    rspPcNext = rspPcReg + XLEN'(4);
                end
            end
            if (rspKeep) begin
                wrPtrNext = wrPtrReg + AW'(1);
            end
            if (pop) begin
                rdPtrNext = rdPtrReg + AW'(1);
            end
            countNext = countReg + cnt_t'(rspKeep) - cnt_t'(pop);

            if (loadOut) begin
                if (queueNonEmpty) begin
                    ifidValidNext = 1'b1;
                    ifidInstNext  = qInst[rdPtrReg];
                    ifidPcNext    = qPc[rdPtrReg];
                end else begin
                    ifidValidNext = 1'b0;
                    ifidInstNext  = NOP_INST;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPcReg   <= RESET_PC;
            rspPcReg     <= RESET_PC;
            countReg     <= '0;
            outstReg     <= '0;
            dropReg      <= '0;
            wrPtrReg     <= '0;
            rdPtrReg     <= '0;
            issueEnReg   <= 1'b0;
            ifidValidReg <= 1'b0;
            ifidInstReg  <= NOP_INST;
            ifidPcReg    <= '0;
        end else begin
            fetchPcReg   <= fetchPcNext;
            rspPcReg     <= rspPcNext;
            countReg     <= countNext;
            outstReg     <= outstNext;
            dropReg      <= dropNext;
            wrPtrReg     <= wrPtrNext;
            rdPtrReg     <= rdPtrNext;
            issueEnReg   <= 1'b1;
            ifidValidReg <= ifidValidNext;
            ifidInstReg  <= ifidInstNext;
            ifidPcReg    <= ifidPcNext;
        end
    end

    // Queue storage needs no reset: count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rspKeep) begin
            qPc[wrPtrReg]   <= rspPcReg;
            qInst[wrPtrReg] <= bus.imemRspData;
        end
    end

    assign bus.imemReqValid = reqValid;
    assign bus.imemReqAddr  = fetchPcReg;
    assign bus.ifidValid    = ifidValidReg;
    assign bus.ifidINST     = ifidInstReg;
    assign bus.ifidPc       = ifidPcReg;
endmodule
